distance_to_note: RTL and testbench
===================================

# distance_to_note

Downstream consumer of the sonar ranging stage. Takes each latched distance sample (inches plus a one-cycle valid strobe), rejects single-sample spikes with a median-of-3 filter, and quantizes the result into a note index with a gate. It also drops the gate when the hand leaves the playing range or the sensor goes silent. Its outputs drive the synth voice/oscillator stage.

## Interface
- `MIN_IN`, 6: distance in inches of the lowest note-band floor.
- `INCH_SHIFT`, 1: log2 of inches per note band (band width = 2^INCH_SHIFT).
- `NUM_NOTES`, 24: number of note bands, at most 32.
- `HYST_IN`, 1: hysteresis margin in inches. Used only with `DIST_NOTE_HYST_EN`.
- `TIMEOUT_CYCLES`, 15_000_000: clocks without a valid sample before the gate drops (150 ms at 100 MHz).
- `clk` input 1: system clock. Everything is on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `distance_in` input 9: distance sample in inches.
- `valid` input 1: one-cycle strobe qualifying `distance_in`.
- `note` output 5: current note index, 0..NUM_NOTES-1.
- `gate` output 1: high while a note is sounding.
- `note_valid` output 1: one-cycle pulse whenever `note` or `gate` changes.

## Operation
- History: 3 × 9-bit shift register plus a fill count that saturates at 3.
  - Each `valid` shifts `distance_in` in and increments the fill count.
  - The median is evaluated only once the fill count is 3.
- Median: the middle value of the three entries, found by pairwise compares. Equal values are handled naturally.
- Range limits: `lo = MIN_IN` and `hi = MIN_IN + (NUM_NOTES << INCH_SHIFT)`. Intermediate arithmetic is 10 bits.
- Out of range (`med < lo` or `med >= hi`):
  - `gate <= 0`; `note` holds its value.
  - `note_valid` pulses only if `gate` was 1.
- In range: `idx = (med - lo) >> INCH_SHIFT`.
  - If `gate` is 0, or `idx != note`, the accept rule applies (see Configuration). On accept: `note <= idx`, `gate <= 1`, and `note_valid` pulses.
  - If `idx == note` and `gate` is 1, nothing changes and there is no pulse.
- Timeout: a 24-bit counter clears on `valid` and otherwise increments, saturating.
  - When the counter reaches `TIMEOUT_CYCLES`: `gate <= 0` (pulse if `gate` was 1), and the fill count clears to 0.
  - Gate re-arms only after 3 fresh samples.
- `valid` and timeout in the same cycle: `valid` wins. The counter clears and no timeout action is taken.
- Reset, including mid-pipeline:
  - Outputs: `note = 0`, `gate = 0`, `note_valid = 0`.
  - Internal state: history and fill count cleared, timeout counter 0, pipeline valid bits cleared. In-flight samples are discarded.

## Timing
- Stage 0 (edge at which `valid` is sampled): history shift and fill-count update.
- Stage 1 (next edge): median registered together with a stage-valid bit, set only if the fill count is now 3.
- Stage 2 (following edge): quantize/decide; `note`, `gate` and `note_valid` update.
- Latency: `note_valid` is high exactly 2 clocks after the `valid` cycle.
- Back-to-back `valid` on consecutive cycles is fully pipelined: one decision per sample, no stalls, no drops.
- The timeout action registers `gate` and `note_valid` directly, with no pipeline delay.
- If a timeout coincides with a stage-2 decision, the stage-2 decision wins for that cycle. The fill-count clear still applies.
- `note_valid` is never high for two consecutive cycles unless two consecutive decisions each cause a change.

## Configuration
- `DIST_NOTE_HYST_EN`, defined: a note-to-note change while `gate` is 1 is accepted only when `med` falls outside the current band widened by `HYST_IN` on each side.
  - The current band is `[lo + (note << INCH_SHIFT), lo + ((note+1) << INCH_SHIFT) - 1]`.
  - The change is accepted only if `med < band_lo - HYST_IN` or `med > band_hi + HYST_IN`; otherwise `note` holds and there is no pulse.
  - Gate-on from 0 and out-of-range gate-off are always immediate.
- `DIST_NOTE_HYST_EN`, undefined: any in-range `idx != note` is accepted immediately. `HYST_IN` is unused.

## Test plan
- Reset: hold `rst_n = 0` while strobing `valid` with 30 → `note = 0`, `gate = 0`, no `note_valid`. After release, a single sample of 30 produces no `note_valid` (fill count is 1).
- Fill and latency: after reset, `valid` three times with 10 → on the third, `note_valid` pulses exactly 2 clocks later with `note = 2`, `gate = 1`.
- Spike rejection: steady 20 (note 7) then one sample of 200, then 20 → median stays 20 and no `note_valid` is ever asserted.
- Out of range: from note 7 / gate 1, apply three samples of 100 → `gate` falls on the second 100's decision (median 100) with one `note_valid` pulse; `note` stays 7. The third 100 gives no pulse.
- Timeout: override `TIMEOUT_CYCLES = 1000`, then gate 1 with no `valid` → `gate` falls with a pulse when the counter reaches 1000. The next two samples of 10 give no gate; the third gives `gate = 1`, `note = 2`.
- Hysteresis: from note 2 (band 10..11), `HYST_IN = 1`, three samples of 12 → with the macro, hold (no pulse); then three samples of 13 → `note = 3` with a pulse. Without the macro, the first 12-median produces `note = 3` immediately.

Source files
------------

// File: rtl/distance_to_note_if.sv
// rtl/distance_to_note_if.sv - sample-in / note-out signal bundle for distance_to_note
interface distance_to_note_if;
  logic [8:0] distance_in;
  logic       valid;
  logic [4:0] note;
  logic       gate;
  logic       note_valid;

  modport master (output distance_in, valid, input note, gate, note_valid);
  modport slave  (input distance_in, valid, output note, gate, note_valid);
endinterface

// File: rtl/distance_to_note.sv
// rtl/distance_to_note.sv - median-of-3 filtered distance to note/gate quantizer
// Optional feature: DIST_NOTE_HYST_EN enables note-change hysteresis.
module distance_to_note #(
  parameter int MIN_IN         = 6,
  parameter int INCH_SHIFT     = 1,
  parameter int NUM_NOTES      = 24,
  parameter int HYST_IN        = 1,
  parameter int TIMEOUT_CYCLES = 15_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  distance_to_note_if.slave dn
);

  localparam logic [9:0]  LO      = 10'(MIN_IN);
  localparam logic [9:0]  HI      = 10'(MIN_IN + (NUM_NOTES << INCH_SHIFT));
  localparam logic [9:0]  HY      = 10'(HYST_IN);
  localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);

  logic [8:0]  hist0, hist1, hist2;
  logic [1:0]  fill;
  logic [23:0] idle_cnt;
  logic        s0_v, s1_v;
  logic [8:0]  med_q;
  logic [4:0]  note_q;
  logic        gate_q, nv_q;

  logic        timeout_fire;
  logic [8:0]  lo_ab, hi_ab, med_c;
  logic [9:0]  med10, idx10, band_lo, band_hi;
  logic [4:0]  idx;
  logic        in_range, accept;

  // Fires once, on the edge where the idle counter reaches TIMEOUT_CYCLES
  assign timeout_fire = !dn.valid && (idle_cnt == TO_LAST);

  always_comb begin
    lo_ab = (hist0 < hist1) ? hist0 : hist1;
    hi_ab = (hist0 < hist1) ? hist1 : hist0;
    med_c = (hi_ab < hist2) ? hi_ab : ((lo_ab > hist2) ? lo_ab : hist2);
  end

  always_comb begin
    med10    = {1'b0, med_q};
    in_range = (med10 >= LO) && (med10 < HI);
    idx10    = (med10 - LO) >> INCH_SHIFT;
    idx      = idx10[4:0];
    band_lo  = LO + ({5'd0, note_q} << INCH_SHIFT);
    band_hi  = band_lo + (10'd1 << INCH_SHIFT) - 10'd1;
`ifdef DIST_NOTE_HYST_EN
    accept   = !gate_q || ((idx != note_q) &&
               ((med10 + HY < band_lo) || (med10 > band_hi + HY)));
`else
    accept   = (!gate_q || (idx != note_q)) && (HYST_IN >= 0);
`endif
  end

  // Stage 0: history, fill count, idle counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist0    <= '0;
      hist1    <= '0;
      hist2    <= '0;
      fill     <= '0;
      idle_cnt <= '0;
      s0_v     <= 1'b0;
    end else begin
      s0_v <= dn.valid;
      if (dn.valid) begin
        hist2    <= hist1;
        hist1    <= hist0;
        hist0    <= dn.distance_in;
        fill     <= (fill == 2'd3) ? 2'd3 : fill + 2'd1;
        idle_cnt <= '0;
      end else begin
        if (idle_cnt != 24'hFF_FFFF)
          idle_cnt <= idle_cnt + 24'd1;
        if (timeout_fire)
          fill <= '0;
      end
    end
  end

  // Stage 1: registered median
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v  <= 1'b0;
      med_q <= '0;
    end else begin
      s1_v  <= s0_v && (fill == 2'd3);
      med_q <= med_c;
    end
  end

  // Stage 2: decision; a stage-2 decision takes precedence over a timeout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      note_q <= '0;
      gate_q <= 1'b0;
      nv_q   <= 1'b0;
    end else begin
      nv_q <= 1'b0;
      if (s1_v) begin
        if (!in_range) begin
          gate_q <= 1'b0;
          nv_q   <= gate_q;
        end else if (accept) begin
          note_q <= idx;
          gate_q <= 1'b1;
          nv_q   <= 1'b1;
        end
      end else if (timeout_fire) begin
        gate_q <= 1'b0;
        nv_q   <= gate_q;
      end
    end
  end

  assign dn.note       = note_q;
  assign dn.gate       = gate_q;
  assign dn.note_valid = nv_q;

endmodule

// File: tb/tb_distance_to_note.sv
// tb/tb_distance_to_note.sv - table-driven bench for distance_to_note
module tb_distance_to_note;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  distance_to_note_if dn();

  distance_to_note #(.TIMEOUT_CYCLES(1000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dn    (dn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] d;
    logic       nv;
    logic [4:0] note;
    logic       gate;
  } vec_t;

  vec_t tbl[$];

`ifdef DIST_NOTE_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One sample; outputs checked two clocks after the sampling edge
  task automatic sample(input logic [8:0] d, input logic exp_nv,
                        input logic [4:0] exp_note, input logic exp_gate,
                        input string tag);
    @(negedge clk);
    dn.distance_in = d;
    dn.valid = 1'b1;
    @(negedge clk);
    dn.valid = 1'b0;
    @(negedge clk);
    chk({tag, " early_nv"}, int'(dn.note_valid), 0);
    @(negedge clk);
    chk({tag, " nv"}, int'(dn.note_valid), int'(exp_nv));
    chk({tag, " note"}, int'(dn.note), int'(exp_note));
    chk({tag, " gate"}, int'(dn.gate), int'(exp_gate));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int elapsed;
    bit dropped;
    dn.distance_in = 9'd30;
    dn.valid = 1'b1;

    // Reset held while valid strobes
    repeat (4) @(negedge clk);
    chk("rst note", int'(dn.note), 0);
    chk("rst gate", int'(dn.gate), 0);
    chk("rst nv", int'(dn.note_valid), 0);
    dn.valid = 1'b0;
    rst_n = 1'b1;
    sample(9'd30, 1'b0, 5'd0, 1'b0, "post_rst");
    do_reset();

    tbl.push_back('{9'd10,  1'b0, 5'd0, 1'b0});
    tbl.push_back('{9'd10,  1'b0, 5'd0, 1'b0});
    tbl.push_back('{9'd10,  1'b1, 5'd2, 1'b1});
    tbl.push_back('{9'd10,  1'b0, 5'd2, 1'b1});
    tbl.push_back('{9'd12,  1'b0, 5'd2, 1'b1});
    if (HYST) begin
      tbl.push_back('{9'd12, 1'b0, 5'd2, 1'b1});
      tbl.push_back('{9'd12, 1'b0, 5'd2, 1'b1});
      tbl.push_back('{9'd13, 1'b0, 5'd2, 1'b1});
      tbl.push_back('{9'd13, 1'b1, 5'd3, 1'b1});
    end else begin
      tbl.push_back('{9'd12, 1'b1, 5'd3, 1'b1});
      tbl.push_back('{9'd12, 1'b0, 5'd3, 1'b1});
      tbl.push_back('{9'd13, 1'b0, 5'd3, 1'b1});
      tbl.push_back('{9'd13, 1'b0, 5'd3, 1'b1});
    end
    tbl.push_back('{9'd13,  1'b0, 5'd3, 1'b1});
    tbl.push_back('{9'd20,  1'b0, 5'd3, 1'b1});
    tbl.push_back('{9'd20,  1'b1, 5'd7, 1'b1});
    tbl.push_back('{9'd20,  1'b0, 5'd7, 1'b1});
    tbl.push_back('{9'd200, 1'b0, 5'd7, 1'b1});
    tbl.push_back('{9'd20,  1'b0, 5'd7, 1'b1});
    tbl.push_back('{9'd20,  1'b0, 5'd7, 1'b1});
    tbl.push_back('{9'd100, 1'b0, 5'd7, 1'b1});
    tbl.push_back('{9'd100, 1'b1, 5'd7, 1'b0});
    tbl.push_back('{9'd100, 1'b0, 5'd7, 1'b0});
    tbl.push_back('{9'd20,  1'b0, 5'd7, 1'b0});
    tbl.push_back('{9'd20,  1'b1, 5'd7, 1'b1});
    tbl.push_back('{9'd20,  1'b0, 5'd7, 1'b1});
    tbl.push_back('{9'd53,  1'b0, 5'd7, 1'b1});
    tbl.push_back('{9'd53,  1'b1, 5'd23, 1'b1});
    tbl.push_back('{9'd54,  1'b0, 5'd23, 1'b1});
    tbl.push_back('{9'd54,  1'b1, 5'd23, 1'b0});
    tbl.push_back('{9'd6,   1'b0, 5'd23, 1'b0});
    tbl.push_back('{9'd6,   1'b1, 5'd0, 1'b1});
    tbl.push_back('{9'd5,   1'b0, 5'd0, 1'b1});
    tbl.push_back('{9'd5,   1'b1, 5'd0, 1'b0});
    tbl.push_back('{9'd10,  1'b0, 5'd0, 1'b0});
    tbl.push_back('{9'd10,  1'b1, 5'd2, 1'b1});

    foreach (tbl[i])
      sample(tbl[i].d, tbl[i].nv, tbl[i].note, tbl[i].gate, $sformatf("vec%0d", i));

    // Timeout: last sample edge was two clocks ago
    elapsed = 2;
    dropped = 1'b0;
    for (int i = 0; i < 2000 && !dropped; i++) begin
      @(negedge clk);
      elapsed++;
      if (!dn.gate) begin
        dropped = 1'b1;
        chk("to nv", int'(dn.note_valid), 1);
        chk("to note", int'(dn.note), 2);
      end
    end
    chk("to dropped", int'(dropped), 1);
    chk("to at_limit", int'(elapsed >= 1000 && elapsed <= 1001), 1);
    @(negedge clk);
    chk("to nv_single", int'(dn.note_valid), 0);
    sample(9'd10, 1'b0, 5'd2, 1'b0, "rearm1");
    sample(9'd10, 1'b0, 5'd2, 1'b0, "rearm2");
    sample(9'd10, 1'b1, 5'd2, 1'b1, "rearm3");

    // Back-to-back samples: 20,20,40,40 on consecutive edges
    @(negedge clk); dn.valid = 1'b1; dn.distance_in = 9'd20;
    @(negedge clk); dn.distance_in = 9'd20;
    @(negedge clk); dn.distance_in = 9'd40;
    @(negedge clk); dn.distance_in = 9'd40;
    chk("b2b nv0", int'(dn.note_valid), 0);
    @(negedge clk); dn.valid = 1'b0;
    chk("b2b nv1", int'(dn.note_valid), 1);
    chk("b2b note1", int'(dn.note), 7);
    @(negedge clk);
    chk("b2b nv2", int'(dn.note_valid), 0);
    @(negedge clk);
    chk("b2b nv3", int'(dn.note_valid), 1);
    chk("b2b note3", int'(dn.note), 17);
    chk("b2b gate3", int'(dn.gate), 1);

    // Reset while samples are in flight
    @(negedge clk); dn.valid = 1'b1; dn.distance_in = 9'd6;
    @(negedge clk); dn.distance_in = 9'd6;
    @(negedge clk); dn.valid = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("mid_rst note", int'(dn.note), 0);
    chk("mid_rst gate", int'(dn.gate), 0);
    chk("mid_rst nv", int'(dn.note_valid), 0);
    @(negedge clk);
    chk("mid_rst nv_a", int'(dn.note_valid), 0);
    @(negedge clk);
    chk("mid_rst nv_b", int'(dn.note_valid), 0);
    sample(9'd30, 1'b0, 5'd0, 1'b0, "mid_rst_fill");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
